// File: rtl/fifo_pkg.sv
// Shared constants for the fifo_sync read-side path.
package fifo_pkg;
  localparam int FIFO_RD_LATENCY = 1;
  localparam int SKID_DEPTH      = 2;
  localparam int SKID_CNT_W      = $clog2(SKID_DEPTH + 1);
endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register FIFO that catches words arriving one clock after their pop.
// Head data is a plain register read, so it holds steady while nothing is popped.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [SKID_CNT_W-1:0] count,
  output logic [data_width-1:0] head
);

  logic [data_width-1:0] mem [SKID_DEPTH];
  logic [0:0]            rd_ptr;
  logic [0:0]            wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops fifo_sync and re-times its registered read data into a valid/ready stream.
// Issue is throttled so buffered plus in-flight words never exceed the skid depth.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic [data_width-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data,
  output logic [cnt_width-1:0]  pop_count,
  output logic                  busy
);

  logic                  inflight;
  logic                  take;
  logic [SKID_CNT_W-1:0] cnt;
  logic [SKID_CNT_W:0]   occ_next;

  assign take = m_valid & m_ready;

  // Occupancy after this edge, excluding any pop issued now; take implies cnt >= 1.
  assign occ_next = {1'b0, cnt}
                  + {{SKID_CNT_W{1'b0}}, inflight}
                  - {{SKID_CNT_W{1'b0}}, take};

  assign fifo_rd_en = ~rst & en & ~fifo_empty
                    & (occ_next < (SKID_CNT_W + 1)'(SKID_DEPTH));
  assign fifo_cs    = fifo_rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= 1'b0;
      pop_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (take) pop_count <= pop_count + 1'b1;
    end
  end

  fifo_skid_buf #(
    .data_width(data_width)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(fifo_data_out),
    .pop      (take),
    .count    (cnt),
    .head     (m_data)
  );

  assign m_valid = (cnt != '0);
  assign busy    = inflight | m_valid;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Pairs fifo_rd_stream with a behavioural depth-8 fifo_sync; scoreboard checks order and counts.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_cs, fifo_rd_en, fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          m_valid, m_ready, busy;
  logic [DW-1:0] m_data;
  logic [CW-1:0] pop_count;

  // fifo_sync model: registered read data, empty derived from registered count
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fmem [8];
  logic [2:0]    wp, rp;
  logic [3:0]    fcount;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] exp_pc;
  int            held;
  int            cyc = 0;
  int            first_rd, first_vld, first_take, last_take;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          stop;

  always #5 clk = ~clk;

  fifo_rd_stream #(.data_width(DW), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_cs(fifo_cs), .fifo_rd_en(fifo_rd_en),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .pop_count(pop_count), .busy(busy)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0; rp <= '0; fcount <= '0; fifo_data_out <= '0;
    end else begin
      if (wr_en && fcount < 4'd8) begin
        fmem[wp] <= wr_data;
        wp <= wp + 3'd1;
      end
      if (fifo_rd_en && fcount != 4'd0) begin
        fifo_data_out <= fmem[rp];
        rp <= rp + 3'd1;
      end
      fcount <= fcount + 4'((wr_en && fcount < 4'd8) ? 1 : 0)
                       - 4'((fifo_rd_en && fcount != 4'd0) ? 1 : 0);
    end
  end
  assign fifo_empty = (fcount == 4'd0);

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, checks each beat the next rising edge will take
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      int nh;
      if (prev_stall) begin
        n_vec++;
        if (!m_valid || m_data !== prev_data) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b d=%0h, want v=1 d=%0h", m_valid, m_data, prev_data);
        end
      end
      if (fifo_rd_en) begin
        n_vec++;
        if (fifo_empty || !fifo_cs) begin
          n_bad++;
          $display("FAIL pop_guard: rd_en=1 with empty=%0b cs=%0b, want empty=0 cs=1", fifo_empty, fifo_cs);
        end
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_beat: got d=%0h, want no beat", m_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          n_vec++;
          if (m_data !== e) begin
            n_bad++;
            $display("FAIL beat_data: got %0h, want %0h", m_data, e);
          end
        end
        n_vec++;
        if (pop_count !== exp_pc) begin
          n_bad++;
          $display("FAIL beat_pop_count: got %0d, want %0d", pop_count, exp_pc);
        end
        exp_pc = exp_pc + 1'b1;
        if (first_take < 0) first_take = cyc;
        last_take = cyc;
      end
      nh = held + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (fifo_rd_en) begin
        n_vec++;
        if (nh > 2) begin
          n_bad++;
          $display("FAIL occupancy: got %0d held+inflight, want <= 2", nh);
        end
      end
      held = nh;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic mark();
    first_rd = -1; first_vld = -1; first_take = -1; last_take = -1;
  endtask

  task automatic write_word(input logic [DW-1:0] v);
    int n = 0;
    while (fcount >= 4'd8 && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      n_vec++; n_bad++;
      $display("FAIL write_timeout: got full for %0d clks, want space", n);
    end
    wr_en = 1'b1; wr_data = v;
    exp_q.push_back(v);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy || fcount != 4'd0) && n < max) begin tick(); n++; end
    n_vec++;
    if (n >= max) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d words pending, want 0", exp_q.size());
    end
  endtask

  // Reset lands mid-cycle, away from any edge, to exercise the asynchronous path
  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete(); exp_pc = '0; held = 0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_pop_count", 32'(pop_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en_cs", {30'd0, fifo_rd_en, fifo_cs}, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    exp_pc = '0; held = 0; prev_stall = 1'b0; stop = 1'b0;
    mark();
    repeat (2) tick();
    chk("init_m_valid", 32'(m_valid), 32'd0);
    chk("init_pop_count", 32'(pop_count), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Three words streamed through with the consumer always ready
    en = 1'b1; m_ready = 1'b1; mark();
    write_word(32'd1); write_word(32'd10); write_word(32'd100);
    wait_idle(50);
    chk("t2_latency", 32'(first_vld - first_rd), 32'd2);
    chk("t2_back_to_back", 32'(last_take - first_take), 32'd2);
    chk("t2_pop_count", 32'(pop_count), 32'd3);
    chk("t2_busy", 32'(busy), 32'd0);

    // Reset while words are held in the skid buffer and the FIFO
    m_ready = 1'b0;
    write_word(32'hA1); write_word(32'hA2); write_word(32'hA3); write_word(32'hA4);
    repeat (4) tick();
    chk("t1_pre_valid", 32'(m_valid), 32'd1);
    chk("t1_pre_data", m_data, 32'hA1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("t1_no_valid", 32'(m_valid), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    write_word(32'h55);
    wait_idle(50);
    chk("t1_pop_count", 32'(pop_count), 32'd1);

    // Eight words queued while disabled, then released as a full-rate burst
    do_reset();
    en = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) write_word(32'(i));
    repeat (3) tick();
    chk("t3_idle_busy", 32'(busy), 32'd0);
    chk("t3_fifo_full", 32'(fcount), 32'd8);
    mark();
    en = 1'b1;
    wait_idle(100);
    chk("t3_back_to_back", 32'(last_take - first_take), 32'd7);
    chk("t3_pop_count", 32'(pop_count), 32'd8);

    // Powers of two with a toggling consumer; pop_count 8+8 wraps to 0
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) write_word(32'd1 << i);
        wait_idle(200);
        stop = 1'b1;
      end
      begin
        int k = 0;
        while (!stop && k < 300) begin
          tick();
          m_ready = ~m_ready;
          k++;
        end
      end
    join
    m_ready = 1'b1;
    chk("t4_pop_count_wrap", 32'(pop_count), 32'd0);

    // Disable with a full buffer: only the two held words drain
    en = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(32'h200 + 32'(i));
    chk("t5_no_pop_valid", 32'(m_valid), 32'd0);
    en = 1'b1;
    repeat (4) tick();
    chk("t5_buffer_valid", 32'(m_valid), 32'd1);
    en = 1'b0; m_ready = 1'b1;
    repeat (6) tick();
    chk("t5_drained_valid", 32'(m_valid), 32'd0);
    chk("t5_pop_count", 32'(pop_count), 32'd2);
    chk("t5_fifo_left", 32'(fcount), 32'd6);
    en = 1'b1;
    wait_idle(100);
    chk("t5_pop_count_end", 32'(pop_count), 32'd8);

    // 18 beats through a 4-bit counter: 15 -> 0 -> 2
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 18; i++) write_word(32'h300 + 32'(i));
    wait_idle(100);
    chk("t6_pop_count_wrap", 32'(pop_count), 32'd2);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
